// File: rtl/datapath_pipe.sv
// datapath_pipe: two-stage register-file/ALU datapath.
// EX reads operands (with one-op write-back forwarding), executes and loads the
// WB register; WB commits the result to the register file on the next edge.
// All outputs come straight from the WB register.
//
// Handshake: the op is accepted on every rising edge where valid=1 and rst=0
// (there is no ready; the pipe never stalls). Outputs for that op appear with
// result_valid=1 for exactly the following cycle.
module datapath_pipe #(
    parameter int WIDTH = 32,
    parameter int NREGS = 4,
    localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic             wr,
    input  logic [AW-1:0]    addr1,
    input  logic [AW-1:0]    addr2,
    input  logic [AW-1:0]    addr3,
    input  logic [2:0]       aluControl,
    input  logic             imm_en,
    input  logic [WIDTH-1:0] imm,
    output logic [WIDTH-1:0] data1,
    output logic [WIDTH-1:0] data2,
    output logic [WIDTH-1:0] data3,
    output logic             result_valid,
    output logic [3:0]       flags
);

    localparam int SW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;
    localparam logic [AW:0] NREGS_W = (AW + 1)'(NREGS);

    // Register file and WB pipeline register
    logic [WIDTH-1:0] regs_q [NREGS];
    logic             wb_valid_q;
    logic             wb_wr_q;
    logic [AW-1:0]    wb_addr_q;
    logic [WIDTH-1:0] wb_a_q;
    logic [WIDTH-1:0] wb_b_q;
    logic [WIDTH-1:0] wb_data_q;
    logic [3:0]       wb_flags_q;

    // EX-stage combinational values
    logic [WIDTH-1:0] rd1, rd2;
    logic             fwd_ok;
    logic [WIDTH-1:0] op_a_d, op_b_d;
    logic [WIDTH-1:0] res_d;
    logic [WIDTH:0]   sum_ext;
    logic             carry_d, ovf_d;
    logic [3:0]       flags_d;

    // Register-file read; out-of-range addresses read as zero
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if ({1'b0, addr1} < NREGS_W) rd1 = regs_q[addr1];
        if ({1'b0, addr2} < NREGS_W) rd2 = regs_q[addr2];
    end

    // Operand select: forward the pending WB result, immediate overrides B.
    // Only in-range destinations forward, since those writes are the only ones
    // that will ever land in the register file.
    always_comb begin
        fwd_ok = wb_valid_q && wb_wr_q && ({1'b0, wb_addr_q} < NREGS_W);
        op_a_d = (fwd_ok && (wb_addr_q == addr1)) ? wb_data_q : rd1;
        if (imm_en)
            op_b_d = imm;
        else if (fwd_ok && (wb_addr_q == addr2))
            op_b_d = wb_data_q;
        else
            op_b_d = rd2;
    end

    // ALU and status flags {zero, neg, carry, ovf}
    always_comb begin
        res_d   = '0;
        sum_ext = '0;
        carry_d = 1'b0;
        ovf_d   = 1'b0;
        case (aluControl)
            3'b000: begin
                sum_ext = {1'b0, op_a_d} + {1'b0, op_b_d};
                res_d   = sum_ext[WIDTH-1:0];
                carry_d = sum_ext[WIDTH];
                ovf_d   = (op_a_d[MSB] == op_b_d[MSB]) && (res_d[MSB] != op_a_d[MSB]);
            end
            3'b001: begin
                // Top bit of the extended difference is the borrow.
                sum_ext = {1'b0, op_a_d} - {1'b0, op_b_d};
                res_d   = sum_ext[WIDTH-1:0];
                carry_d = ~sum_ext[WIDTH];
                ovf_d   = (op_a_d[MSB] != op_b_d[MSB]) && (res_d[MSB] != op_a_d[MSB]);
            end
            3'b010: res_d = op_a_d & op_b_d;
            3'b011: res_d = op_a_d | op_b_d;
            3'b100: res_d = op_a_d ^ op_b_d;
            3'b101: res_d = {{(WIDTH-1){1'b0}}, ($signed(op_a_d) < $signed(op_b_d))};
            3'b110: res_d = op_a_d << op_b_d[SW-1:0];
            3'b111: res_d = op_a_d >> op_b_d[SW-1:0];
            default: res_d = '0;
        endcase
        flags_d = {(res_d == '0), res_d[MSB], carry_d, ovf_d};
    end

    // Pipeline state: reset clears everything; otherwise commit WB then reload it
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
            wb_valid_q <= 1'b0;
            wb_wr_q    <= 1'b0;
            wb_addr_q  <= '0;
            wb_a_q     <= '0;
            wb_b_q     <= '0;
            wb_data_q  <= '0;
            wb_flags_q <= '0;
        end else begin
            if (fwd_ok) regs_q[wb_addr_q] <= wb_data_q;
            wb_valid_q <= valid;
            if (valid) begin
                wb_wr_q    <= wr;
                wb_addr_q  <= addr3;
                wb_a_q     <= op_a_d;
                wb_b_q     <= op_b_d;
                wb_data_q  <= res_d;
                wb_flags_q <= flags_d;
            end
        end
    end

    assign data1        = wb_a_q;
    assign data2        = wb_b_q;
    assign data3        = wb_data_q;
    assign flags        = wb_flags_q;
    assign result_valid = wb_valid_q;

endmodule

// File: tb/tb_datapath_pipe.sv
// tb_datapath_pipe: directed scenarios plus randomized ops, checked against an
// architectural model where each op sees all earlier ops' writes in order.
module tb_datapath_pipe;

    logic        clk = 1'b0;
    logic        rst, valid, wr, imm_en;
    logic [1:0]  addr1, addr2, addr3;
    logic [2:0]  aluControl;
    logic [31:0] imm;
    logic [31:0] data1, data2, data3;
    logic        result_valid;
    logic [3:0]  flags;

    int checks = 0;
    int failures = 0;

    logic [31:0] m_regs [4];
    logic [31:0] exp_q [$];

    datapath_pipe #(.WIDTH(32), .NREGS(4)) dut (
        .clk(clk), .rst(rst), .valid(valid), .wr(wr),
        .addr1(addr1), .addr2(addr2), .addr3(addr3),
        .aluControl(aluControl), .imm_en(imm_en), .imm(imm),
        .data1(data1), .data2(data2), .data3(data3),
        .result_valid(result_valid), .flags(flags)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference ALU from plain arithmetic on wide signed/unsigned integers
    function automatic void ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] res, output logic [3:0] fl);
        longint sa, sb, ua, ub, s;
        logic c, o;
        logic [31:0] bb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        bb = b;
        c = 1'b0;
        o = 1'b0;
        case (op)
            3'd0: begin
                res = a + b;
                c = (ua + ub) > 64'sd4294967295;
                s = sa + sb;
                o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd1: begin
                res = a - b;
                c = (ua >= ub);
                s = sa - sb;
                o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd2: res = a & b;
            3'd3: res = a | b;
            3'd4: res = a ^ b;
            3'd5: res = (sa < sb) ? 32'd1 : 32'd0;
            3'd6: res = a << bb[4:0];
            default: res = a >> bb[4:0];
        endcase
        fl = {(res == 32'd0), res[31], c, o};
    endfunction

    // Driver: apply one cycle of inputs, update the model at the edge, check after it
    task automatic step(input bit r, input bit v, input bit w,
                        input logic [1:0] a1, input logic [1:0] a2, input logic [1:0] a3,
                        input logic [2:0] op, input bit ie, input logic [31:0] im);
        logic [31:0] a, b, res;
        logic [3:0]  fl;
        a = '0; b = '0; res = '0; fl = '0;
        rst = r; valid = v; wr = w;
        addr1 = a1; addr2 = a2; addr3 = a3;
        aluControl = op; imm_en = ie; imm = im;
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 4; i++) m_regs[i] = '0;
        end else if (v) begin
            a = m_regs[a1];
            b = ie ? im : m_regs[a2];
            ref_alu(op, a, b, res, fl);
            if (w) m_regs[a3] = res;
            exp_q.push_back(res);
        end
        #1;
        if (r) begin
            check_eq("rst_valid", {31'b0, result_valid}, 32'd0);
            check_eq("rst_data1", data1, 32'd0);
            check_eq("rst_data2", data2, 32'd0);
            check_eq("rst_data3", data3, 32'd0);
            check_eq("rst_flags", {28'b0, flags}, 32'd0);
        end else if (v) begin
            check_eq("valid", {31'b0, result_valid}, 32'd1);
            check_eq("data1", data1, a);
            check_eq("data2", data2, b);
            check_eq("flags", {28'b0, flags}, {28'b0, fl});
            check_eq("data3", data3, exp_q.pop_front());
        end else begin
            check_eq("idle_valid", {31'b0, result_valid}, 32'd0);
        end
    endtask

    initial begin
        rst = 1'b0; valid = 1'b0; wr = 1'b0; imm_en = 1'b0;
        addr1 = '0; addr2 = '0; addr3 = '0; aluControl = '0; imm = '0;
        for (int i = 0; i < 4; i++) m_regs[i] = '0;

        // Reset state
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 1, 2, 3, 0, 1, 32'h55);

        // sub r1 = r3 - r3
        step(0, 1, 1, 3, 3, 1, 3'd1, 0, 0);
        check_eq("tp_sub_d3", data3, 32'd0);
        check_eq("tp_sub_flags", {28'b0, flags}, 32'b1010);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 1, 0, 0, 3'd0, 1, 0);
        check_eq("tp_r1_read", data1, 32'd0);

        // Back-to-back forwarding
        step(0, 1, 1, 1, 0, 0, 3'd1, 1, 1);
        check_eq("tp_fwd1_d3", data3, 32'hFFFF_FFFF);
        check_eq("tp_fwd1_flags", {28'b0, flags}, 32'b0100);
        step(0, 1, 1, 0, 0, 2, 3'd0, 1, 1);
        check_eq("tp_fwd2_d1", data1, 32'hFFFF_FFFF);
        check_eq("tp_fwd2_d3", data3, 32'd0);
        check_eq("tp_fwd2_flags", {28'b0, flags}, 32'b1010);

        // Overflow: clear r0, then 0x7FFFFFFF + 1
        step(0, 1, 1, 0, 0, 0, 3'd2, 1, 0);
        step(0, 1, 1, 0, 0, 1, 3'd0, 1, 32'h7FFF_FFFF);
        step(0, 1, 1, 1, 0, 1, 3'd0, 1, 1);
        check_eq("tp_ovf_d3", data3, 32'h8000_0000);
        check_eq("tp_ovf_flags", {28'b0, flags}, 32'b0101);

        // wr=0 leaves r2 untouched
        step(0, 1, 0, 1, 0, 2, 3'd0, 1, 5);
        check_eq("tp_nowr_d3", data3, 32'h8000_0005);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 2, 0, 0, 3'd0, 1, 0);
        check_eq("tp_nowr_r2", data1, 32'd0);

        // Reset while a write is pending in WB
        step(0, 1, 1, 0, 0, 3, 3'd0, 1, 7);
        step(1, 1, 1, 0, 0, 2, 3'd0, 1, 9);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 3, 0, 0, 3'd0, 1, 0);
        check_eq("tp_rstmid_r3", data1, 32'd0);

        // Shifts and slt
        step(0, 1, 1, 0, 0, 1, 3'd0, 1, 1);
        step(0, 1, 1, 1, 0, 1, 3'd6, 1, 31);
        check_eq("tp_shl", data3, 32'h8000_0000);
        step(0, 1, 1, 0, 0, 0, 3'd1, 1, 1);
        step(0, 1, 0, 0, 0, 3, 3'd5, 1, 0);
        check_eq("tp_slt", data3, 32'd1);
        step(0, 1, 1, 1, 0, 2, 3'd7, 1, 31);
        check_eq("tp_shr", data3, 32'd1);

        // Randomized ops, with occasional resets and bubbles
        for (int n = 0; n < 600; n++) begin
            logic [31:0] im;
            im = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 33)) : $urandom;
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) != 0), ($urandom_range(0, 3) != 0),
                 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 3'($urandom_range(0, 7)), ($urandom_range(0, 1) == 1), im);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
